// File: rtl/tensor_core_sequencer_if.sv
// ============================================================================
// Module : tensor_core_sequencer_if
// Brief  : Operand, tensor-core register-file and result port bundle for the sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tensor_core_sequencer_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 start_in;
    logic                 operand_valid_in;
    logic [BUS_WIDTH-1:0] operand_data_in;
    logic                 operand_ready_out;
    logic                 tc_write_enable_out;
    logic [4:0]           tc_write_address_out;
    logic [BUS_WIDTH-1:0] tc_write_data_out;
    logic                 tc_operate_out;
    logic                 tc_done_in;
    logic [3:0]           tc_read_address_out;
    logic [BUS_WIDTH-1:0] tc_read_data_in;
    logic                 result_valid_out;
    logic [BUS_WIDTH-1:0] result_data_out;
    logic                 result_ready_in;
    logic                 busy_out;
    logic                 job_done_out;
    logic                 error_out;

    // master: the sequencer; slave: front end plus tensor core
    modport master (
        input  start_in, operand_valid_in, operand_data_in, tc_done_in,
               tc_read_data_in, result_ready_in,
        output operand_ready_out, tc_write_enable_out, tc_write_address_out,
               tc_write_data_out, tc_operate_out, tc_read_address_out,
               result_valid_out, result_data_out, busy_out, job_done_out,
               error_out
    );

    modport slave (
        output start_in, operand_valid_in, operand_data_in, tc_done_in,
               tc_read_data_in, result_ready_in,
        input  operand_ready_out, tc_write_enable_out, tc_write_address_out,
               tc_write_data_out, tc_operate_out, tc_read_address_out,
               result_valid_out, result_data_out, busy_out, job_done_out,
               error_out
    );
endinterface

`default_nettype wire

// File: rtl/tensor_core_sequencer.sv
// ============================================================================
// Module : tensor_core_sequencer
// Brief  : Loads both operand matrices, pulses operate, waits for done and
//          streams the result matrix out. Optional watchdog via
//          TENSOR_CORE_SEQUENCER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_core_sequencer #(
    parameter int BUS_WIDTH      = 8,
    parameter int DIM            = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                clock_in,
    input  wire logic                reset_n_in,
    tensor_core_sequencer_if.master  bus
);

    localparam logic [4:0] c_LAST_OPER = 5'(2 * DIM * DIM - 1);
    localparam logic [4:0] c_LAST_RES  = 5'(DIM * DIM - 1);

    generate
        if (DIM < 1 || 2 * DIM * DIM > 32 || DIM * DIM > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("tensor_core_sequencer: unsupported DIM/TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_OPERATE   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    state_t               r_state;
    logic [4:0]           r_idx;
    logic                 r_wr_en;
    logic [4:0]           r_wr_addr;
    logic [BUS_WIDTH-1:0] r_wr_data;
    logic                 r_operate;
    logic                 r_res_valid;
    logic [BUS_WIDTH-1:0] r_res_data;
    logic                 r_job_done;
    logic                 w_oper_hs;
    logic                 w_timeout;

    assign w_oper_hs = (r_state == ST_LOAD) && bus.operand_valid_in;

`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
    localparam int               c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0]  c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0]  c_TONE  = c_TW'(1);

    logic [c_TW-1:0] r_timer;
    logic            r_error;

    assign w_timeout     = (r_timer == c_TLAST);
    assign bus.error_out = r_error;

    // Timer is held at zero outside WAIT_DONE, so every entry starts from 0
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_timer <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= (r_state == ST_WAIT_DONE) && !bus.tc_done_in && w_timeout;
            if (r_state == ST_WAIT_DONE) begin
                r_timer <= r_timer + c_TONE;
            end else begin
                r_timer <= '0;
            end
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign bus.error_out = 1'b0;
`endif

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_state     <= ST_IDLE;
            r_idx       <= 5'd0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= '0;
            r_operate   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_job_done  <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_operate  <= 1'b0;
            r_job_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The job-done pulse cycle is still IDLE; a start there is dropped
                    if (bus.start_in && !r_job_done) begin
                        r_state <= ST_LOAD;
                        r_idx   <= 5'd0;
                    end
                end
                ST_LOAD: begin
                    if (w_oper_hs) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx;
                        r_wr_data <= bus.operand_data_in;
                        if (r_idx == c_LAST_OPER) begin
                            r_state   <= ST_OPERATE;
                            r_operate <= 1'b1;
                            r_idx     <= 5'd0;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_OPERATE: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.tc_done_in) begin
                        r_state     <= ST_DRAIN;
                        r_idx       <= 5'd0;
                        r_res_valid <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!r_res_valid) begin
                        r_res_data  <= bus.tc_read_data_in;
                        r_res_valid <= 1'b1;
                    end else if (bus.result_ready_in) begin
                        r_res_valid <= 1'b0;
                        if (r_idx == c_LAST_RES) begin
                            r_job_done <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_idx      <= 5'd0;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.operand_ready_out    = (r_state == ST_LOAD);
    assign bus.tc_write_enable_out  = r_wr_en;
    assign bus.tc_write_address_out = r_wr_addr;
    assign bus.tc_write_data_out    = r_wr_data;
    assign bus.tc_operate_out       = r_operate;
    assign bus.tc_read_address_out  = (r_state == ST_DRAIN) ? r_idx[3:0] : 4'd0;
    assign bus.result_valid_out     = r_res_valid;
    assign bus.result_data_out      = r_res_data;
    assign bus.busy_out             = (r_state != ST_IDLE);
    assign bus.job_done_out         = r_job_done;

endmodule

`default_nettype wire

// File: tb/tb_tensor_core_sequencer.sv
// ============================================================================
// Module : tb_tensor_core_sequencer
// Brief  : Directed self-checking bench for tensor_core_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tensor_core_sequencer;

    localparam int BW   = 8;
    localparam int DIM  = 3;
    localparam int NOP  = 18;
    localparam int NRES = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tensor_core_sequencer_if #(.BUS_WIDTH(BW)) bus ();

    tensor_core_sequencer #(
        .BUS_WIDTH      (BW),
        .DIM            (DIM),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    logic [7:0] ops     [NOP];
    logic [7:0] res_mem [NRES];

    assign bus.tc_read_data_in = (bus.tc_read_address_out < 4'(NRES)) ?
                                 res_mem[bus.tc_read_address_out] : 8'h00;

    int         n_checks = 0;
    int         n_errors = 0;
    int         wr_cnt, op_cnt, jd_cnt, err_cnt;
    logic [4:0] wr_addr [64];
    logic [7:0] wr_data [64];
    logic [7:0] res_q   [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tensor-core side log: writes, operate pulses, accepted results, stall stability
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.tc_write_enable_out) begin
                if (wr_cnt < 64) begin
                    wr_addr[wr_cnt] = bus.tc_write_address_out;
                    wr_data[wr_cnt] = bus.tc_write_data_out;
                end
                wr_cnt++;
            end
            if (bus.tc_operate_out) op_cnt++;
            if (bus.job_done_out)   jd_cnt++;
            if (bus.error_out)      err_cnt++;
            if (bus.result_valid_out && bus.result_ready_in) res_q.push_back(bus.result_data_out);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, bus.result_valid_out}, 32'd1);
                chk("hold_data", {24'd0, bus.result_data_out}, {24'd0, prev_data});
            end
            prev_stall = bus.result_valid_out && !bus.result_ready_in;
            prev_data  = bus.result_data_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_cnt  = 0;
        op_cnt  = 0;
        jd_cnt  = 0;
        err_cnt = 0;
        res_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   {31'd0, bus.operand_ready_out},   0);
        chk({tag, "_wr_en"},   {31'd0, bus.tc_write_enable_out}, 0);
        chk({tag, "_wr_addr"}, {27'd0, bus.tc_write_address_out}, 0);
        chk({tag, "_wr_data"}, {24'd0, bus.tc_write_data_out},   0);
        chk({tag, "_operate"}, {31'd0, bus.tc_operate_out},      0);
        chk({tag, "_rd_addr"}, {28'd0, bus.tc_read_address_out}, 0);
        chk({tag, "_valid"},   {31'd0, bus.result_valid_out},    0);
        chk({tag, "_rdata"},   {24'd0, bus.result_data_out},     0);
        chk({tag, "_busy"},    {31'd0, bus.busy_out},            0);
        chk({tag, "_jobdone"}, {31'd0, bus.job_done_out},        0);
        chk({tag, "_error"},   {31'd0, bus.error_out},           0);
    endtask

    task automatic load_ops(input bit toggle, input int count);
        int  i   = 0;
        int  cyc = 0;
        bit  hs;
        while (i < count && cyc < 400) begin
            bus.operand_valid_in = !toggle || (cyc % 2 == 0);
            bus.operand_data_in  = ops[i];
            hs = bus.operand_valid_in && bus.operand_ready_out;
            tick();
            cyc++;
            if (hs) i++;
        end
        bus.operand_valid_in = 1'b0;
        chk("load_count", i, count);
    endtask

    // Start a job, stream all operands and stop in the first WAIT_DONE cycle
    task automatic to_wait(input bit toggle);
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy_out}, 1);
        load_ops(toggle, NOP);
        chk("operate_pulse",   {31'd0, bus.tc_operate_out},      1);
        chk("final_wr_en",     {31'd0, bus.tc_write_enable_out}, 1);
        chk("final_wr_addr",   {27'd0, bus.tc_write_address_out}, 17);
        chk("final_wr_data",   {24'd0, bus.tc_write_data_out},   {24'd0, ops[17]});
        chk("ready_dropped",   {31'd0, bus.operand_ready_out},   0);
        tick();
        chk("operate_one_cycle", {31'd0, bus.tc_operate_out}, 0);
    endtask

    task automatic drain(input bit slow, input bit poke_start);
        int n   = 0;
        int cyc = 0;
        bit acc;
        while (n < NRES && cyc < 400) begin
            bus.result_ready_in = !slow || (cyc % 3 == 2);
            bus.start_in        = poke_start && (cyc == 4);
            acc = bus.result_valid_out && bus.result_ready_in;
            tick();
            cyc++;
            if (acc) n++;
        end
        bus.result_ready_in = 1'b0;
        bus.start_in        = 1'b0;
        chk("drain_count", n, NRES);
    endtask

    task automatic check_job_logs();
        chk("wr_count", wr_cnt, NOP);
        for (int k = 0; k < NOP && k < wr_cnt; k++) begin
            chk("wr_addr", {27'd0, wr_addr[k]}, k);
            chk("wr_data", {24'd0, wr_data[k]}, {24'd0, ops[k]});
        end
        chk("res_count", res_q.size(), NRES);
        for (int k = 0; k < NRES && k < res_q.size(); k++) begin
            chk("res_data", {24'd0, res_q[k]}, {24'd0, res_mem[k]});
        end
        chk("op_count", op_cnt, 1);
        chk("jobdone_count", jd_cnt, 1);
        chk("error_count", err_cnt, 0);
    endtask

    task automatic job(input bit toggle, input bit slow, input bit poke,
                       input bit start_on_done, input bit stale);
        if (stale) bus.tc_done_in = 1'b1;
        to_wait(toggle);
        bus.tc_done_in = 1'b0;
        repeat (3) begin
            tick();
            chk("wait_no_valid", {31'd0, bus.result_valid_out}, 0);
            chk("wait_busy", {31'd0, bus.busy_out}, 1);
        end
        bus.tc_done_in = 1'b1;
        tick();
        chk("drain_entry_no_valid", {31'd0, bus.result_valid_out}, 0);
        chk("rd_addr_first", {28'd0, bus.tc_read_address_out}, 0);
        tick();
        bus.tc_done_in = 1'b0;
        chk("first_valid", {31'd0, bus.result_valid_out}, 1);
        chk("first_data", {24'd0, bus.result_data_out}, {24'd0, res_mem[0]});
        drain(slow, poke);
        chk("job_done_pulse", {31'd0, bus.job_done_out}, 1);
        chk("idle_after_job", {31'd0, bus.busy_out}, 0);
        bus.start_in = start_on_done;
        tick();
        bus.start_in = 1'b0;
        chk("job_done_one_cycle", {31'd0, bus.job_done_out}, 0);
        chk("start_on_done_ignored", {31'd0, bus.busy_out}, 0);
        tick(3);
        chk("idle_stays", {31'd0, bus.busy_out}, 0);
        check_job_logs();
    endtask

    initial begin
        bus.start_in         = 1'b0;
        bus.operand_valid_in = 1'b0;
        bus.operand_data_in  = 8'h00;
        bus.tc_done_in       = 1'b0;
        bus.result_ready_in  = 1'b0;
        for (int k = 0; k < NOP; k++)  ops[k] = 8'h00;
        for (int k = 0; k < NRES; k++) res_mem[k] = 8'h00;
        clear_logs();

        rst_n = 1'b0;
        tick(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Identity job: matrix 0 identity, matrix 1 = 1..9, results 1..9
        for (int k = 0; k < 9; k++) begin
            ops[k]     = (k % 4 == 0) ? 8'd1 : 8'd0;
            ops[9 + k] = 8'(k + 1);
            res_mem[k] = 8'(k + 1);
        end
        clear_logs();
        job(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure with signed extremes
        for (int k = 0; k < NOP; k++) ops[k] = 8'(k * 37 + 3);
        ops[0]  = 8'h80;
        ops[17] = 8'h7F;
        res_mem[0] = 8'h80; res_mem[1] = 8'h7F; res_mem[2] = 8'hFF;
        res_mem[3] = 8'h00; res_mem[4] = 8'h01; res_mem[5] = 8'hFE;
        res_mem[6] = 8'd100; res_mem[7] = 8'h9C; res_mem[8] = 8'd55;
        clear_logs();
        job(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of LOAD, then a clean job
        for (int k = 0; k < NOP; k++) ops[k] = 8'(200 - k * 5);
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        load_ops(1'b0, 7);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midload_reset");
        rst_n = 1'b1;
        tick();
        clear_logs();
        job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Operands offered in IDLE are ignored; start pulsed during DRAIN
        clear_logs();
        bus.operand_valid_in = 1'b1;
        bus.operand_data_in  = 8'h55;
        repeat (4) begin
            tick();
            chk("idle_ready_low", {31'd0, bus.operand_ready_out}, 0);
        end
        bus.operand_valid_in = 1'b0;
        chk("idle_no_writes", wr_cnt, 0);
        chk("idle_not_busy", {31'd0, bus.busy_out}, 0);
        job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stale done held through LOAD and the operate cycle
        clear_logs();
        job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // No done after operate
        clear_logs();
        to_wait(1'b0);
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
        tick(63);
        chk("to_no_error_yet", {31'd0, bus.error_out}, 0);
        chk("to_still_busy", {31'd0, bus.busy_out}, 1);
        tick();
        chk("to_error_pulse", {31'd0, bus.error_out}, 1);
        chk("to_idle", {31'd0, bus.busy_out}, 0);
        tick();
        chk("to_error_one_cycle", {31'd0, bus.error_out}, 0);
        chk("to_no_results", res_q.size(), 0);
        chk("to_no_jobdone", jd_cnt, 0);
        chk("to_error_count", err_cnt, 1);

        // Done on the final watchdog cycle wins
        clear_logs();
        to_wait(1'b0);
        tick(63);
        bus.tc_done_in = 1'b1;
        tick();
        chk("late_done_no_error", {31'd0, bus.error_out}, 0);
        chk("late_done_busy", {31'd0, bus.busy_out}, 1);
        tick();
        bus.tc_done_in = 1'b0;
        chk("late_done_valid", {31'd0, bus.result_valid_out}, 1);
        drain(1'b0, 1'b0);
        tick();
        check_job_logs();
`else
        tick(100);
        chk("wait_forever_busy", {31'd0, bus.busy_out}, 1);
        chk("wait_forever_no_error", {31'd0, bus.error_out}, 0);
        chk("wait_forever_no_results", res_q.size(), 0);
        chk("wait_forever_error_count", err_cnt, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("final_idle", {31'd0, bus.busy_out}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
